serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/serial_compare_ctrl_pkg.sv | 18 +
 rtl/serial_compare_ctrl_nibble_cmp.sv | 16 +
 rtl/serial_compare_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_compare_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and constants for the serial nibble-by-nibble magnitude comparator.
package serial_compare_ctrl_pkg;

    localparam int NIBBLES_DEFAULT = 4;
    localparam int NIBBLE_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Digit index width, never narrower than one bit even for a single digit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_nibble_cmp.sv
// Combinational unsigned comparison of one 4-bit digit pair.
module nibble_cmp
    import serial_compare_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    output logic                lt_o,
    output logic                eq_o,
    output logic                gr_o
);

    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
    assign gr_o = (a_i >  b_i);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial unsigned comparator: walks the operands one nibble per cycle from the
// most significant digit and stops at the first differing digit.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    output logic                    busy,
    output logic                    done,
    output logic                    lt,
    output logic                    eq,
    output logic                    gr
);

    localparam int                IDX_W   = idx_width(NIBBLES);
    localparam int                OP_W    = NIBBLE_W * NIBBLES;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [OP_W-1:0]   a_q,     a_d;
    logic [OP_W-1:0]   b_q,     b_d;
    logic              lt_q,    lt_d;
    logic              eq_q,    eq_d;
    logic              gr_q,    gr_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic                nib_lt;
    logic                nib_eq;
    logic                nib_gr;

    assign nib_a = NIBBLE_W'(a_q >> (idx_q * NIBBLE_W));
    assign nib_b = NIBBLE_W'(b_q >> (idx_q * NIBBLE_W));

    nibble_cmp u_nibble_cmp (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .lt_o (nib_lt),
        .eq_o (nib_eq),
        .gr_o (nib_gr)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gr_d    = gr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_TOP;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (nib_gr) begin
                    {lt_d, eq_d, gr_d} = 3'b001;
                    state_d            = ST_DONE;
                end else if (nib_lt) begin
                    {lt_d, eq_d, gr_d} = 3'b100;
                    state_d            = ST_DONE;
                end else if (idx_q == '0) begin
                    {lt_d, eq_d, gr_d} = 3'b010;
                    state_d            = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status is decoded from the state register, so reset clears it without a clock edge.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign lt = lt_q;
    assign eq = eq_q;
    assign gr = gr_q;

    // NOTE: async active-low reset in the sensitivity list; non-blocking assignments for all state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gr_q    <= gr_d;
        end
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl at NIBBLES=4 and NIBBLES=1.
module tb_serial_compare_ctrl;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gr;
        int   acc;   // cycle number of the edge that accepts start
        int   dn;    // cycle number in which done must be seen
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        busy4, done4, lt4, eq4, gr4;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, lt1, eq1, gr1;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[2][$];
    logic [2:0]  last_f[2] = '{3'b000, 3'b000};
    logic [4:0]  obs[2];

    serial_compare_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .lt(lt4), .eq(eq4), .gr(gr4)
    );

    serial_compare_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .lt(lt1), .eq(eq1), .gr(gr1)
    );

    assign obs[0] = {busy4, done4, lt4, eq4, gr4};
    assign obs[1] = {busy1, done1, lt1, eq1, gr1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unsigned compare of the whole operands; latency is the number
    // of digits scanned from the top up to and including the first difference.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input int n, input int acc);
        exp_t        e;
        logic [31:0] diff;
        int          k;
        diff = a ^ b;
        k    = n;
        for (int i = 0; i < n; i++)
            if (((diff >> (4 * i)) & 32'hF) != 0) k = n - i;
        e.lt  = (a < b);
        e.eq  = (a == b);
        e.gr  = (a > b);
        e.acc = acc;
        e.dn  = acc + k;
        return e;
    endfunction

    // Monitor: compares busy, done and the held flags every cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic eb, ed;
            eb = (sb_q[d].size() > 0) && (cyc >= sb_q[d][0].acc);
            ed = (sb_q[d].size() > 0) && (cyc == sb_q[d][0].dn);
            check($sformatf("busy[dut%0d]", d), obs[d][4], eb);
            check($sformatf("done[dut%0d]", d), obs[d][3], ed);
            if (ed) begin
                last_f[d] = {sb_q[d][0].lt, sb_q[d][0].eq, sb_q[d][0].gr};
                void'(sb_q[d].pop_front());
            end
            check($sformatf("lt_eq_gr[dut%0d]", d), obs[d][2:0], last_f[d]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (sb_q[d].size() > 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb_q[d].size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout[dut%0d]: %0d results pending, required 0", d, sb_q[d].size());
            sb_q[d].delete();
        end
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm;
        wait_idle(d);
        am = (d == 0) ? (a & 32'hFFFF) : (a & 32'hF);
        bm = (d == 0) ? (b & 32'hFFFF) : (b & 32'hF);
        sb_q[d].push_back(model(am, bm, (d == 0) ? 4 : 1, cyc + 1));
        if (d == 0) begin start4 = 1'b1; a4 = am[15:0]; b4 = bm[15:0]; end
        else        begin start1 = 1'b1; a1 = am[3:0];  b1 = bm[3:0];  end
        tick();
        // Operands are scrambled after acceptance; the result must not notice.
        if (d == 0) begin start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); end
        else        begin start1 = 1'b0; a1 = 4'($urandom);  b1 = 4'($urandom);  end
    endtask

    task automatic spurious_start(input int d);
        if (d == 0) begin start4 = 1'b1; a4 = 16'($urandom); b4 = 16'($urandom); end
        else        begin start1 = 1'b1; a1 = 4'($urandom);  b1 = 4'($urandom);  end
        tick();
        if (d == 0) start4 = 1'b0; else start1 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("reset_busy4", busy4, 1'b0);
        check("reset_flags4", {done4, lt4, eq4, gr4}, 4'b0000);
        rst_n = 1'b1;

        // Directed cases on the 4-digit instance.
        issue(0, 32'h1234, 32'h1234);
        issue(0, 32'h9000, 32'h1000);
        issue(0, 32'h0012, 32'h0013);
        issue(0, 32'hFFFF, 32'h0000);

        // Second start while running is ignored.
        issue(0, 32'h5000, 32'h5001);
        start4 = 1'b1; a4 = 16'h0000; b4 = 16'hFFFF;
        tick();
        start4 = 1'b0;
        wait_idle(0);

        // Reset in the middle of a comparison aborts it immediately.
        issue(0, 32'h1111, 32'h1112);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy4", busy4, 1'b0);
        check("abort_done4", done4, 1'b0);
        check("abort_flags4", {lt4, eq4, gr4}, 3'b000);
        check("abort_flags1", {busy1, done1, lt1, eq1, gr1}, 5'b00000);
        sb_q[0].delete();
        sb_q[1].delete();
        last_f[0] = 3'b000;
        last_f[1] = 3'b000;
        tick();
        rst_n = 1'b1;
        issue(0, 32'h2000, 32'h1000);
        wait_idle(0);

        // Random trials, biased toward long equal prefixes to exercise every latency.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 1000; t++) begin
                logic [31:0] ra, rb;
                int          w;
                w  = (d == 0) ? 16 : 4;
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = $urandom;
                    1:       rb = ra;
                    default: rb = ra ^ (32'h1 << $urandom_range(0, w - 1));
                endcase
                issue(d, ra, rb);
                if ($urandom_range(0, 3) == 0) spurious_start(d);
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle(d);
        end

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
